// File: rtl/song_note_feeder_if.sv
// Note-window handshake between the song feeder (master) and the game core / song ROM (slave).
// The master side drives the ROM address, lane windows and status; the slave side drives control and ROM data.
interface song_note_feeder_if #(
    parameter int ADDR_W = 7,
    parameter int WIN_W  = 32
);
    logic              start;
    logic              abort;
    logic              beat;
    logic [ADDR_W-1:0] rom_addr;
    logic [1:0]        rom_data;
    logic [WIN_W-1:0]  notes1;
    logic [WIN_W-1:0]  notes2;
    logic [ADDR_W-1:0] beat_idx;
    logic              busy;
    logic              done;
    logic              overrun;

    modport master (
        input  start, abort, beat, rom_data,
        output rom_addr, notes1, notes2, beat_idx, busy, done, overrun
    );

    modport slave (
        output start, abort, beat, rom_data,
        input  rom_addr, notes1, notes2, beat_idx, busy, done, overrun
    );
endinterface

// File: rtl/song_note_feeder.sv
// Streams a stored song into two lane windows, one note pair per beat.
// It prefetches each pair from a synchronous ROM and drains the windows to zero after the last beat.
module song_note_feeder #(
    parameter int SONG_LEN = 128,
    parameter int ADDR_W   = 7,
    parameter int WIN_W    = 32
) (
    input  logic                clk,
    input  logic                n_rst,
    song_note_feeder_if.master  bus
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, READY, DRAIN, DONE} state_t;

    // beat_idx saturates at SONG_LEN, or at the largest count ADDR_W bits can hold if that is smaller.
    localparam int                IDX_CAP    = (SONG_LEN > (2**ADDR_W) - 1) ? (2**ADDR_W) - 1 : SONG_LEN;
    localparam logic [ADDR_W-1:0] IDX_MAX    = ADDR_W'(IDX_CAP);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(SONG_LEN - 1);
    localparam logic [5:0]        DRAIN_LAST = 6'(WIN_W - 1);

    state_t     state;
    logic [1:0] prefetch;
    logic       pending;
    logic [5:0] drain_cnt;

    function automatic logic [WIN_W-1:0] shift_in(input logic [WIN_W-1:0] win, input logic b);
        return {win[WIN_W-2:0], b};
    endfunction

    function automatic logic [ADDR_W-1:0] next_idx(input logic [ADDR_W-1:0] idx);
        return (idx == IDX_MAX) ? IDX_MAX : idx + ADDR_W'(1);
    endfunction

    // NOTE: all state in this block uses non-blocking assignments, so every branch reads pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            prefetch     <= '0;
            pending      <= 1'b0;
            drain_cnt    <= '0;
            bus.rom_addr <= '0;
            bus.notes1   <= '0;
            bus.notes2   <= '0;
            bus.beat_idx <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.overrun  <= 1'b0;
        end else if (bus.abort) begin
            state        <= IDLE;
            prefetch     <= '0;
            pending      <= 1'b0;
            drain_cnt    <= '0;
            bus.rom_addr <= '0;
            bus.notes1   <= '0;
            bus.notes2   <= '0;
            bus.beat_idx <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.overrun  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state        <= FETCH;
                        bus.busy     <= 1'b1;
                        bus.notes1   <= '0;
                        bus.notes2   <= '0;
                        bus.beat_idx <= '0;
                        bus.overrun  <= 1'b0;
                        drain_cnt    <= '0;
                        pending      <= 1'b0;
                    end
                end
                FETCH: begin
                    bus.rom_addr <= bus.beat_idx;
                    state        <= WAIT;
                    if (bus.beat) begin
                        if (pending) bus.overrun <= 1'b1;
                        else         pending     <= 1'b1;
                    end
                end
                WAIT: begin
                    prefetch <= bus.rom_data;
                    // A beat arriving in WAIT is serviced on this same exit edge; a second one is lost.
                    if (pending || bus.beat) begin
                        bus.notes1   <= shift_in(bus.notes1, bus.rom_data[0]);
                        bus.notes2   <= shift_in(bus.notes2, bus.rom_data[1]);
                        bus.beat_idx <= next_idx(bus.beat_idx);
                        pending      <= 1'b0;
                        state        <= (bus.beat_idx == LAST_IDX) ? DRAIN : FETCH;
                        if (pending && bus.beat) bus.overrun <= 1'b1;
                    end else begin
                        state <= READY;
                    end
                end
                READY: begin
                    if (bus.beat) begin
                        bus.notes1   <= shift_in(bus.notes1, prefetch[0]);
                        bus.notes2   <= shift_in(bus.notes2, prefetch[1]);
                        bus.beat_idx <= next_idx(bus.beat_idx);
                        state        <= (bus.beat_idx == LAST_IDX) ? DRAIN : FETCH;
                    end
                end
                DRAIN: begin
                    if (bus.beat) begin
                        bus.notes1 <= shift_in(bus.notes1, 1'b0);
                        bus.notes2 <= shift_in(bus.notes2, 1'b0);
                        drain_cnt  <= drain_cnt + 6'd1;
                        if (drain_cnt == DRAIN_LAST) begin
                            state    <= DONE;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_song_note_feeder.sv
// Directed bench for song_note_feeder with a four-beat song {01,10,11,00}.
// Expected window contents are worked out by hand from the shift order.
module tb_song_note_feeder;
    localparam int SONG_LEN = 4;
    localparam int ADDR_W   = 7;
    localparam int WIN_W    = 32;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   done_seen = 0;
    logic [1:0] rom [0:(2**ADDR_W)-1];

    song_note_feeder_if #(.ADDR_W(ADDR_W), .WIN_W(WIN_W)) bus ();

    song_note_feeder #(.SONG_LEN(SONG_LEN), .ADDR_W(ADDR_W), .WIN_W(WIN_W)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // The registered rom_addr acts as the synchronous ROM's address register.
    assign bus.rom_data = rom[bus.rom_addr];

    always @(posedge clk) if (bus.done === 1'b1) done_seen <= done_seen + 1;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_beat();
        bus.beat = 1'b1;
        tick();
        bus.beat = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) rom[i] = 2'b00;
        rom[0] = 2'b01;
        rom[1] = 2'b10;
        rom[2] = 2'b11;
        rom[3] = 2'b00;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.beat  = 1'b0;

        // Reset state
        #2;
        check("rst_notes1", bus.notes1, 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_rom_addr", 32'(bus.rom_addr), 32'h0);
        repeat (2) tick();
        n_rst = 1'b1;
        tick();

        // Song of four beats, ten cycles apart
        pulse_start();
        check("start_busy", 32'(bus.busy), 32'h1);
        repeat (9) tick();
        pulse_beat();
        check("b1_notes1", bus.notes1, 32'h1);
        check("b1_notes2", bus.notes2, 32'h0);
        check("b1_idx", 32'(bus.beat_idx), 32'd1);
        repeat (9) tick();
        pulse_beat();
        check("b2_notes1", bus.notes1, 32'h2);
        check("b2_notes2", bus.notes2, 32'h1);
        repeat (9) tick();
        pulse_beat();
        check("b3_notes1", bus.notes1, 32'h5);
        check("b3_notes2", bus.notes2, 32'h3);
        repeat (9) tick();
        pulse_beat();
        check("b4_notes1", bus.notes1, 32'hA);
        check("b4_notes2", bus.notes2, 32'h6);
        check("b4_idx", 32'(bus.beat_idx), 32'd4);
        check("b4_busy", 32'(bus.busy), 32'h1);

        // Drain: 29 beats leave the top bits, 3 more clear the windows
        for (int i = 0; i < 29; i++) begin
            pulse_beat();
            tick();
        end
        check("d29_notes1", bus.notes1, 32'h4000_0000);
        check("d29_notes2", bus.notes2, 32'hC000_0000);
        check("d29_busy", 32'(bus.busy), 32'h1);
        check("d29_done", 32'(bus.done), 32'h0);
        pulse_beat(); tick();
        pulse_beat(); tick();
        pulse_beat();
        check("drain_done", 32'(bus.done), 32'h1);
        check("drain_busy", 32'(bus.busy), 32'h0);
        check("drain_notes1", bus.notes1, 32'h0);
        check("drain_notes2", bus.notes2, 32'h0);
        check("drain_idx_sat", 32'(bus.beat_idx), 32'd4);
        tick();
        check("done_one_cycle", 32'(bus.done), 32'h0);

        // Beat during FETCH is held pending and shifted on WAIT exit
        pulse_start();
        bus.beat = 1'b1;
        tick();
        bus.beat = 1'b0;
        tick();
        check("pend_notes1", bus.notes1, 32'h1);
        check("pend_notes2", bus.notes2, 32'h0);
        check("pend_idx", 32'(bus.beat_idx), 32'd1);
        check("pend_overrun", 32'(bus.overrun), 32'h0);

        // Beats in FETCH and WAIT back to back: one shift, overrun set
        bus.beat = 1'b1;
        tick();
        tick();
        bus.beat = 1'b0;
        check("ovr_notes1", bus.notes1, 32'h2);
        check("ovr_notes2", bus.notes2, 32'h1);
        check("ovr_idx", 32'(bus.beat_idx), 32'd2);
        check("ovr_flag", 32'(bus.overrun), 32'h1);

        // start while busy is ignored; overrun stays sticky
        pulse_start();
        check("busy_start_idx", 32'(bus.beat_idx), 32'd2);
        check("busy_start_notes1", bus.notes1, 32'h2);
        check("busy_start_ovr", 32'(bus.overrun), 32'h1);
        tick();

        // abort together with start: abort wins, no done pulse
        bus.abort = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'h0);
        check("abort_notes1", bus.notes1, 32'h0);
        check("abort_notes2", bus.notes2, 32'h0);
        check("abort_idx", 32'(bus.beat_idx), 32'd0);
        check("abort_rom_addr", 32'(bus.rom_addr), 32'd0);
        check("abort_overrun", 32'(bus.overrun), 32'h0);
        tick();
        check("abort_stays_idle", 32'(bus.busy), 32'h0);
        check("abort_done", 32'(bus.done), 32'h0);

        // Reset asserted mid-DRAIN clears everything without a clock edge
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            tick();
            tick();
            pulse_beat();
        end
        for (int i = 0; i < 5; i++) pulse_beat();
        check("mid_drain_notes1", bus.notes1, 32'h140);
        check("mid_drain_notes2", bus.notes2, 32'hC0);
        #2;
        n_rst = 1'b0;
        #1;
        check("arst_notes1", bus.notes1, 32'h0);
        check("arst_notes2", bus.notes2, 32'h0);
        check("arst_idx", 32'(bus.beat_idx), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'h0);
        check("arst_rom_addr", 32'(bus.rom_addr), 32'd0);
        tick();
        n_rst = 1'b1;
        pulse_beat();
        check("idle_beat_ignored", bus.notes1, 32'h0);
        tick();
        check("done_total", 32'(done_seen), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
